// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the fetch PC, issues one word
// read at a time over req/ack, buffers {pc, instr} in a small FIFO and
// presents the head to the decoder with valid/ready. A redirect flushes
// all buffered and in-flight work and restarts fetch at a new address.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a non word-aligned target parks the unit in
//               FAULT (misaligned_o=1, no requests) until a valid redirect.
//   undefined : redirect_pc_i[1:0] forced to 00, misaligned_o stays 0.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   imem_req_o, imem_addr_o   read request / word address
//   imem_ack_i, imem_rdata_i  request accepted, data valid same cycle
//   ir_o, pc_o, ir_valid_o    FIFO head (zero when empty)
//   ir_ready_i                decoder consumes head
//   redirect_i, redirect_pc_i flush and restart fetch
//   misaligned_o              fetch fault indicator
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] ir_o,
   output logic [31:0] pc_o,
   output logic        ir_valid_o,
   input  logic        ir_ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        misaligned_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      DISCARD,
      FAULT
   } state_t;

   state_t        r_state;
   logic [31:0]   r_fpc;
   logic [31:0]   r_req_addr;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic          r_fault_pend;
   logic          r_misaligned;
   logic [31:0]   r_ir_mem [FIFO_DEPTH];
   logic [31:0]   r_pc_mem [FIFO_DEPTH];

   logic          w_req;
   logic          w_pending;
   logic          w_push;
   logic          w_pop;
   logic          w_nempty;
   logic          w_bad;
   logic [31:0]   w_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_tgt = redirect_pc_i;
   assign w_bad = (redirect_pc_i[1:0] != 2'b00);
`else
   assign w_tgt = redirect_pc_i & 32'hFFFF_FFFC;
   assign w_bad = 1'b0;
`endif

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Request is a pure decode of registered state and count, so it
   // cannot change mid-handshake: count only grows on an ack.
   assign w_req = ((r_state == RUN) && (r_count < FULL))
                | (r_state == DISCARD);
   assign w_pending = w_req & ~imem_ack_i;
   assign w_nempty  = (r_count != '0);
   assign w_push    = (r_state == RUN) & w_req & imem_ack_i & ~redirect_i;
   assign w_pop     = w_nempty & ir_ready_i & ~redirect_i;

   assign imem_req_o   = w_req;
   assign imem_addr_o  = (r_state == DISCARD) ? r_req_addr : r_fpc;
   assign ir_valid_o   = w_nempty;
   assign ir_o         = w_nempty ? r_ir_mem[r_rd_ptr] : '0;
   assign pc_o         = w_nempty ? r_pc_mem[r_rd_ptr] : '0;
   assign misaligned_o = r_misaligned;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state      <= BOOT;
         r_fpc        <= RESET_PC;
         r_req_addr   <= RESET_PC;
         r_count      <= '0;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_fault_pend <= 1'b0;
         r_misaligned <= 1'b0;
      end else if (redirect_i) begin
         r_fpc        <= w_tgt;
         r_count      <= '0;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_fault_pend <= w_bad;
         r_misaligned <= 1'b0;
         if (w_pending) begin
            // Keep the abandoned request alive until memory acks it.
            r_state <= DISCARD;
            if (r_state != DISCARD)
               r_req_addr <= r_fpc;
         end else if (w_bad) begin
            r_state      <= FAULT;
            r_misaligned <= 1'b1;
         end else begin
            r_state <= RUN;
         end
      end else begin
         unique case (r_state)
            BOOT: r_state <= RUN;
            RUN: begin
               if (w_push)
                  r_fpc <= r_fpc + 32'd4;
            end
            DISCARD: begin
               if (imem_ack_i) begin
                  r_state      <= r_fault_pend ? FAULT : RUN;
                  r_misaligned <= r_fault_pend;
               end
            end
            FAULT: r_state <= FAULT;
         endcase
         if (w_push)
            r_wr_ptr <= nxt(r_wr_ptr);
         if (w_pop)
            r_rd_ptr <= nxt(r_rd_ptr);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_ir_mem[r_wr_ptr] <= imem_rdata_i;
         r_pc_mem[r_wr_ptr] <= r_fpc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed timing scenarios plus randomized traffic for
// fetch_unit, checked against a program-order model of the fetch stream.
module tb_fetch_unit;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic [31:0] ir_o;
   logic [31:0] pc_o;
   logic        ir_valid_o;
   logic        ir_ready_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        misaligned_o;

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .ir_o          (ir_o),
      .pc_o          (pc_o),
      .ir_valid_o    (ir_valid_o),
      .ir_ready_i    (ir_ready_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .misaligned_o  (misaligned_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_pops = 0;
   int          lat = 0;
   int          wait_cnt = 0;
   logic [31:0] exp_pc = '0;
   logic        prev_redir = 1'b0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] acks [$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Instruction memory contents: 0x13 (nop) at address 0.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0000_0013 : ((a ^ 32'hC0DE_0000) + 32'h13);
   endfunction

   // One clock cycle: memory answers the current request, the stream
   // model observes this cycle, then the clock advances to #1 past posedge.
   task automatic cyc();
      logic a;
      a = imem_req_o && (wait_cnt >= lat);
      imem_ack_i   = a;
      imem_rdata_i = a ? memf(imem_addr_o) : 32'hDEAD_BEEF;
      if (!reset_i) begin
         if (prev_redir)
            check("flush_valid", 32'(ir_valid_o), 32'd0);
         if (prev_hold) begin
            check("hold_req", 32'(imem_req_o), 32'd1);
            check("hold_addr", imem_addr_o, prev_addr);
         end
         if (!ir_valid_o) begin
            check("empty_ir", ir_o, 32'd0);
            check("empty_pc", pc_o, 32'd0);
         end
         if (ir_valid_o && ir_ready_i && !redirect_i) begin
            check("seq_pc", pc_o, exp_pc);
            check("seq_ir", ir_o, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pops++;
         end
         if (a)
            acks.push_back(imem_addr_o);
         if (redirect_i)
            exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
      end
      prev_redir = redirect_i && !reset_i;
      prev_hold  = imem_req_o && !a && !reset_i;
      prev_addr  = imem_addr_o;
      wait_cnt   = (imem_req_o && !a) ? wait_cnt + 1 : 0;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      reset_i    = 1'b1;
      redirect_i = 1'b0;
      ir_ready_i = 1'b0;
      cyc();
      check("rst_req_drop", 32'(imem_req_o), 32'd0);
      cyc();
      check("rst_addr", imem_addr_o, 32'h0);
      check("rst_ir", ir_o, 32'h0);
      check("rst_pc", pc_o, 32'h0);
      check("rst_valid", 32'(ir_valid_o), 32'd0);
      check("rst_mis", 32'(misaligned_o), 32'd0);
      reset_i = 1'b0;
      exp_pc  = 32'h0;
      acks.delete();
   endtask

   initial begin
      bit seen;
      #1;
      // Boot timing with zero-wait memory.
      lat = 0;
      do_reset();
      ir_ready_i = 1'b1;
      check("boot_req", 32'(imem_req_o), 32'd0);
      cyc();
      check("c1_req", 32'(imem_req_o), 32'd1);
      check("c1_addr", imem_addr_o, 32'h0);
      cyc();
      check("c2_valid", 32'(ir_valid_o), 32'd1);
      check("c2_pc", pc_o, 32'h0);
      check("c2_ir", ir_o, 32'h0000_0013);
      cyc();
      check("c3_pc", pc_o, 32'h4);
      cyc();
      check("c4_pc", pc_o, 32'h8);

      // Back-pressure: FIFO fills after two acks.
      do_reset();
      repeat (8) cyc();
      check("bp_nacks", 32'(acks.size()), 32'd2);
      check("bp_ack0", acks[0], 32'h0);
      check("bp_ack1", acks[1], 32'h4);
      check("bp_req_off", 32'(imem_req_o), 32'd0);
      ir_ready_i = 1'b1;
      cyc();
      ir_ready_i = 1'b0;
      check("bp_req8", 32'(imem_req_o), 32'd1);
      check("bp_addr8", imem_addr_o, 32'h8);
      repeat (4) cyc();
      check("bp_nacks2", 32'(acks.size()), 32'd3);
      check("bp_ack2", acks[2], 32'h8);
      check("bp_req_off2", 32'(imem_req_o), 32'd0);
      check("bp_head", pc_o, 32'h4);

      // Redirect while a slow request is outstanding.
      do_reset();
      lat = 3;
      ir_ready_i = 1'b1;
      cyc();
      cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      cyc();
      redirect_i = 1'b0;
      check("dis_req", 32'(imem_req_o), 32'd1);
      check("dis_addr", imem_addr_o, 32'h0);
      cyc();
      check("dis_addr2", imem_addr_o, 32'h0);
      cyc();
      check("dis_new_req", 32'(imem_req_o), 32'd1);
      check("dis_new_addr", imem_addr_o, 32'h100);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (ir_valid_o) seen = 1'b1;
         else cyc();
      end
      check("dis_seen", 32'(seen), 32'd1);
      check("dis_first_pc", pc_o, 32'h100);
      lat = 0;

      // Redirect coinciding with an ack.
      do_reset();
      ir_ready_i = 1'b1;
      cyc();
      cyc();
      cyc();
      check("co_addr8", imem_addr_o, 32'h8);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      cyc();
      redirect_i = 1'b0;
      check("co_req", 32'(imem_req_o), 32'd1);
      check("co_addr", imem_addr_o, 32'h200);
      cyc();
      check("co_valid", 32'(ir_valid_o), 32'd1);
      check("co_pc", pc_o, 32'h200);
      repeat (3) cyc();

      // Misaligned redirect.
      do_reset();
      ir_ready_i = 1'b1;
      cyc();
      cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h102;
      cyc();
      redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      check("mis_flag", 32'(misaligned_o), 32'd1);
      check("mis_req", 32'(imem_req_o), 32'd0);
      check("mis_valid", 32'(ir_valid_o), 32'd0);
      cyc();
      cyc();
      check("mis_req2", 32'(imem_req_o), 32'd0);
      check("mis_flag2", 32'(misaligned_o), 32'd1);
`else
      check("mis_flag", 32'(misaligned_o), 32'd0);
      check("mis_req", 32'(imem_req_o), 32'd1);
      check("mis_addr", imem_addr_o, 32'h100);
      cyc();
`endif
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h300;
      cyc();
      redirect_i = 1'b0;
      check("mis_clr", 32'(misaligned_o), 32'd0);
      check("mis_req300", 32'(imem_req_o), 32'd1);
      check("mis_addr300", imem_addr_o, 32'h300);

      // Address wrap at the top of memory.
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      cyc();
      redirect_i = 1'b0;
      check("wrap_top", imem_addr_o, 32'hFFFF_FFFC);
      cyc();
      check("wrap_zero", imem_addr_o, 32'h0);
      repeat (3) cyc();

      // Randomized traffic against the fetch stream model.
      do_reset();
      n_pops = 0;
      for (int i = 0; i < 3000; i++) begin
         ir_ready_i = ($urandom_range(0, 3) != 0);
         lat        = $urandom_range(0, 3);
         redirect_i = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 3) == 0)
            redirect_pc_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else
            redirect_pc_i = $urandom();
`ifdef FETCH_MISALIGN_CHECK_EN
         redirect_pc_i = redirect_pc_i & 32'hFFFF_FFFC;
`endif
         cyc();
      end
      redirect_i = 1'b0;
      check("rand_progress", 32'(n_pops > 300), 32'd1);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
